// File: rtl/div_iter_param.sv
// Parametrised iterative restoring divider with start/ready handshake, annul and divide-by-zero flag.
// Optional macro DIV_EARLY_OUT_EN: finish in one step when |dividend| < |divisor|.
module div_iter_param #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 div_zero_o
);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH:0]   work;         // {partial remainder, dividend/quotient bits}
   logic [WIDTH-1:0]   divisor_mag;
   logic               q_neg;
   logic               r_neg;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH+1:0]   diff;
   logic [2*WIDTH:0]   work_next;
   logic [WIDTH-1:0]   quo_raw;
   logic [WIDTH-1:0]   rem_raw;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   early_rem;

   always_comb begin
      a_neg = signed_div_i & opdata1_i[WIDTH-1];
      b_neg = signed_div_i & opdata2_i[WIDTH-1];
      a_mag = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
      b_mag = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
   end

   // Trial subtraction on the shifted partial remainder; the top guard bit is always zero.
   always_comb begin
      diff = {work[2*WIDTH], work[2*WIDTH-1:WIDTH-1]} - {2'b00, divisor_mag};
      if (diff[WIDTH+1])
         work_next = {work[2*WIDTH-1:WIDTH-1], work[WIDTH-2:0], 1'b0};
      else
         work_next = {diff[WIDTH:0], work[WIDTH-2:0], 1'b1};
   end

   always_comb begin
      quo_raw   = work[WIDTH-1:0];
      rem_raw   = work[2*WIDTH-1:WIDTH];
      quo_fix   = q_neg ? (~quo_raw + 1'b1) : quo_raw;
      rem_fix   = r_neg ? (~rem_raw + 1'b1) : rem_raw;
      early_rem = r_neg ? (~quo_raw + 1'b1) : quo_raw;
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FREE;
         cnt         <= '0;
         work        <= '0;
         divisor_mag <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         result_o    <= '0;
         ready_o     <= 1'b0;
         busy_o      <= 1'b0;
         div_zero_o  <= 1'b0;
      end else begin
         case (state)
            FREE: begin
               if (start_i && !annul_i) begin
                  work        <= {{(WIDTH+1){1'b0}}, a_mag};
                  divisor_mag <= b_mag;
                  q_neg       <= a_neg ^ b_neg;
                  r_neg       <= a_neg;
                  cnt         <= '0;
                  busy_o      <= 1'b1;
                  state       <= (opdata2_i == '0) ? BYZERO : ON;
               end
            end

            BYZERO: begin
               if (annul_i) begin
                  state  <= FREE;
                  busy_o <= 1'b0;
               end else begin
                  state      <= END;
                  result_o   <= '0;
                  div_zero_o <= 1'b1;
                  ready_o    <= 1'b1;
               end
            end

            ON: begin
               if (annul_i) begin
                  state  <= FREE;
                  busy_o <= 1'b0;
                  cnt    <= '0;
`ifdef DIV_EARLY_OUT_EN
               end else if (cnt == '0 && work[WIDTH-1:0] < divisor_mag) begin
                  state    <= END;
                  result_o <= {early_rem, {WIDTH{1'b0}}};
                  ready_o  <= 1'b1;
`endif
               end else if (cnt == CNT_W'(WIDTH)) begin
                  state    <= END;
                  result_o <= {rem_fix, quo_fix};
                  ready_o  <= 1'b1;
               end else begin
                  work <= work_next;
                  cnt  <= cnt + 1'b1;
               end
            end

            END: begin
               if (!start_i) begin
                  state      <= FREE;
                  result_o   <= '0;
                  ready_o    <= 1'b0;
                  div_zero_o <= 1'b0;
                  busy_o     <= 1'b0;
                  cnt        <= '0;
               end
            end

            default: begin
               state  <= FREE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter_param.sv
// Self-checking bench for div_iter_param: directed cases plus randomized operands vs an arithmetic model.
module tb_div_iter_param;

`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;

   logic        sdiv, start, annul;
   logic [31:0] op1, op2;
   logic [63:0] result;
   logic        ready, busy, dz;

   logic        sdiv_16, start_16, annul_16;
   logic [15:0] op1_16, op2_16;
   logic [31:0] result_16;
   logic        ready_16, busy_16, dz_16;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   div_iter_param #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .signed_div_i(sdiv), .opdata1_i(op1), .opdata2_i(op2),
      .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready),
      .busy_o(busy), .div_zero_o(dz)
   );

   div_iter_param #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .signed_div_i(sdiv_16), .opdata1_i(op1_16), .opdata2_i(op2_16),
      .start_i(start_16), .annul_i(annul_16), .result_o(result_16), .ready_o(ready_16),
      .busy_o(busy_16), .div_zero_o(dz_16)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division (truncating), remainder takes the dividend's sign.
   function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [63:0] res, output logic zero, output int lat);
      longint sa, sb, q, r, ma, mb;
      if (b == 32'd0) begin
         res = 64'd0; zero = 1'b1; lat = 1;
         return;
      end
      sa = sgn ? longint'($signed(a)) : longint'(a);
      sb = sgn ? longint'($signed(b)) : longint'(b);
      q  = sa / sb;
      r  = sa % sb;
      res  = {r[31:0], q[31:0]};
      zero = 1'b0;
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      lat = (EARLY && ma < mb) ? 1 : 33;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] exp_res;
      logic        exp_dz;
      int          exp_lat;
      int          n;
      model(sgn, a, b, exp_res, exp_dz, exp_lat);
      sdiv = sgn; op1 = a; op2 = b; start = 1'b1;
      tick();                                   // edge E0 latches the operands
      op1 = $urandom; op2 = $urandom; sdiv = ~sgn;
      n = 0;
      while (!ready && n < 100) begin
         tick();
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'(exp_lat));
      check({tag, " result"}, result, exp_res);
      check({tag, " div_zero"}, 64'(dz), 64'(exp_dz));
      check({tag, " busy"}, 64'(busy), 64'd1);
      tick();
      check({tag, " hold"}, {result[62:0], ready}, {exp_res[62:0], 1'b1});
      start = 1'b0;
      tick();
      check({tag, " release"}, {result, 1'b0} | 64'({ready, busy, dz}), 64'd0);
   endtask

   initial begin
      logic seen_ready;
      int   n;

      rst = 1'b1;
      sdiv = 0; start = 0; annul = 0; op1 = 0; op2 = 0;
      sdiv_16 = 0; start_16 = 0; annul_16 = 0; op1_16 = 0; op2_16 = 0;
      tick();
      tick();
      rst = 1'b0;
      check("reset result", result, 64'd0);
      check("reset flags", 64'({ready, busy, dz}), 64'd0);

      run_div("u100_7", 1'b0, 32'd100, 32'd7);
      run_div("s-100_7", 1'b1, 32'hFFFF_FF9C, 32'd7);
      run_div("s100_-7", 1'b1, 32'd100, 32'hFFFF_FFF9);
      run_div("div0", 1'b0, 32'd1234, 32'd0);
      run_div("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_div("u5_9", 1'b0, 32'd5, 32'd9);

      // start and annul together in FREE: annul wins
      start = 1'b1; annul = 1'b1; op1 = 32'd50; op2 = 32'd5;
      tick();
      check("start_annul busy", 64'(busy), 64'd0);
      start = 1'b0; annul = 1'b0;
      tick();

      // annul at step 10, then an immediate new request
      sdiv = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
      tick();
      seen_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen_ready |= ready;
      end
      annul = 1'b1;
      tick();
      annul = 1'b0;
      check("annul busy", 64'(busy), 64'd0);
      check("annul ready", 64'({seen_ready, ready}), 64'd0);
      check("annul result", result, 64'd0);
      run_div("u9_2", 1'b0, 32'd9, 32'd2);

      // annul in BYZERO
      op1 = 32'd7; op2 = 32'd0; start = 1'b1;
      tick();
      annul = 1'b1;
      tick();
      annul = 1'b0; start = 1'b0;
      check("annul byzero", 64'({ready, busy, dz}), 64'd0);

      // synchronous reset in the middle of ON
      op1 = 32'd100; op2 = 32'd7; start = 1'b1;
      tick();
      repeat (5) tick();
      rst = 1'b1;
      tick();
      check("midreset result", result, 64'd0);
      check("midreset flags", 64'({ready, busy, dz}), 64'd0);
      rst = 1'b0; start = 1'b0;
      tick();

      // randomized operands
      for (int i = 0; i < 24; i++) begin
         logic        s;
         logic [31:0] a, b;
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = $urandom;
            1: b = $urandom_range(1, 255);
            2: b = (i % 6 == 0) ? 32'd0 : 32'($urandom_range(1, 65535));
            default: b = s ? (~32'($urandom_range(1, 50)) + 1) : 32'($urandom_range(1, 50));
         endcase
         if (i % 5 == 0) a = $urandom_range(0, 40);
         run_div($sformatf("rand%0d", i), s, a, b);
      end

      // narrower variant: 100/7 at WIDTH=16
      op1_16 = 16'd100; op2_16 = 16'd7; start_16 = 1'b1;
      tick();
      n = 0;
      while (!ready_16 && n < 100) begin
         tick();
         n++;
      end
      check("w16 latency", 64'(n), 64'd17);
      check("w16 result", 64'(result_16), 64'({16'd2, 16'd14}));
      start_16 = 1'b0;
      tick();
      check("w16 release", 64'({ready_16, busy_16, dz_16}), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
